fp_add_seq: RTL and testbench
=============================

Name: fp_add_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder controller.
- Accepts two operands as split sign/exponent/mantissa fields, the same field split the operand packer uses.
- Sequences align, add, normalise and round over fixed pipeline states, then presents a packed 32-bit result.
- Sits between the FPU operand packing stage and the FPU result bus, replacing the raw integer sum of packed words.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width.
- MAX_SHIFT, 26, alignment shift clamp; shifts beyond this collapse to sticky.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- s  in  1  sign A.
- e  in  EXP_W  exponent A.
- m  in  MAN_W  mantissa A.
- s0  in  1  sign B.
- e0  in  EXP_W  exponent B.
- m0  in  MAN_W  mantissa B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- add  out  1+EXP_W+MAN_W  packed result {sign, exp, man}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, add=0. All internal registers are cleared.
- Reset mid-operation aborts immediately. No partial result is ever emitted.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
- Transitions:
  - IDLE: in_ready=1. When in_valid=1, operands are captured and the state goes to ALIGN.
  - ALIGN -> ADD -> NORM -> ROUND -> OUT: unconditional, one cycle each.
  - OUT: out_valid=1, add held stable. When out_ready=1, go to IDLE.
- Latency: out_valid rises 5 clock edges after the accept edge, counting the accept edge as edge 1.
- Throughput: one operation per 6 cycles minimum.
- in_ready=0 outside IDLE. in_valid outside IDLE is ignored and not queued.
- Unpack: hidden bit = 1 when exp != 0.
- Denormals (exp=0) are flushed to zero with their sign kept.
- ALIGN:
  - Swap so the larger magnitude is operand A (exp first, then mantissa).
  - Right-shift B's significand by the exponent difference, clamped to MAX_SHIFT.
  - Shifted-out bits are kept as guard, round and sticky.
- ADD: effective add or subtract decided by s XOR s0. The datapath is 28 bits wide (carry, hidden, 23 mantissa, G, R, S).
- NORM:
  - On carry-out: shift right 1 (sticky ORs in the dropped bit), exp+1.
  - Otherwise: left-shift by the leading-zero count and subtract it from exp, all in one cycle.
  - exp underflow to <=0 flushes to +0.
- ROUND:
  - Round to nearest, ties to even, using G/R/S.
  - Mantissa overflow from rounding increments exp.
  - exp >= 255 gives signed infinity (exp=255, man=0).
- Sign and zero rules:
  - Exact cancellation gives +0.
  - (-0)+(-0) gives -0. Any other zero sum gives +0.
  - Result sign is the sign of the larger-magnitude operand.
- Simultaneous out_ready=1 in OUT and in_valid=1: the pair is not accepted that cycle. Acceptance happens from IDLE on the next cycle.
- add keeps its last value in IDLE and changes only on the ROUND->OUT transition.

Optional Feature:
- Macro: FP_ADD_SPECIAL_EN.
- Defined:
  - Any operand with exp=255 and man!=0 (NaN) gives 0x7FC00000.
  - +Inf plus -Inf gives 0x7FC00000.
  - Inf plus finite gives that Inf.
  - Latency is unchanged; the special result is still presented in OUT after the same 5 edges.
- Not defined: exp=255 operands are treated as ordinary finite values. Overflow still saturates to infinity.

Test Plan:
- Reset with rst_n=0 held 3 cycles -> in_ready=1, out_valid=0, busy=0, add=0x00000000.
- 0x3F800000 + 0x3F800000 (1.0+1.0), out_ready=1 -> add=0x40000000, out_valid on edge 5 after accept, back in IDLE next cycle.
- 0x3FC00000 + 0xBFC00000 (1.5 + -1.5) -> add=0x00000000. 0x80000000 + 0x80000000 -> add=0x80000000.
- Rounding ties:
  - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even, down).
  - 0x3F800000 + 0x34400000 -> 0x3F800002 (tie to even, up).
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. With FP_ADD_SPECIAL_EN: 0x7F800000 + 0xFF800000 -> 0x7FC00000.
- Backpressure and reset:
  - out_ready=0 for 10 cycles in OUT -> add and out_valid held stable, in_ready=0, in_valid pulses ignored.
  - rst_n pulsed low in NORM -> immediate IDLE, no out_valid.

Source files
------------

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single-precision adder (align, add, normalise, round).
// Define FP_ADD_SPECIAL_EN to give NaN/Inf operands IEEE special-case results.
module fp_add_seq #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int MAX_SHIFT = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 s,
  input  logic [EXP_W-1:0]     e,
  input  logic [MAN_W-1:0]     m,
  input  logic                 s0,
  input  logic [EXP_W-1:0]     e0,
  input  logic [MAN_W-1:0]     m0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] add,
  output logic                 busy
);

  localparam int SIG_W = MAN_W + 1;  // hidden + stored mantissa
  localparam int EXT_W = SIG_W + 3;  // + guard, round, sticky
  localparam int SUM_W = EXT_W + 1;  // + carry
  localparam int LZ_W  = $clog2(EXT_W);
  localparam int XE_W  = EXP_W + 2;  // two's-complement exponent with headroom

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] SHIFT_CAP = EXP_W'(MAX_SHIFT);
  localparam logic [XE_W-1:0]  EXP_INF   = {2'b00, EXP_MAX};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

  state_t state_q, state_d;

  // Captured operands (denormals already flushed to a zero significand).
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [SIG_W-1:0] a_sig, b_sig;

  // Aligned operands: big_* is always the larger magnitude.
  logic             big_s, eff_sub, neg_zero;
  logic [EXP_W-1:0] big_e;
  logic [EXT_W-1:0] big_x, small_x;

  logic [SUM_W-1:0] sum_q;

  logic             n_zero, n_s;
  logic [XE_W-1:0]  n_exp;
  logic [EXT_W-1:0] n_sig;

`ifdef FP_ADD_SPECIAL_EN
  logic                 sp_hit_q;
  logic [EXP_W+MAN_W:0] sp_res_q;
  logic                 sp_hit_d;
  logic [EXP_W+MAN_W:0] sp_res_d;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its neighbours.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ALIGN;
      end
      ALIGN: state_d = ADD;
      ADD:   state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- unpack
  logic [SIG_W-1:0] in_sig_a, in_sig_b;

  always_comb begin
    in_sig_a = (e  != '0) ? {1'b1, m}  : '0;
    in_sig_b = (e0 != '0) ? {1'b1, m0} : '0;
  end

`ifdef FP_ADD_SPECIAL_EN
  // Special operands are resolved at capture; the sequence still runs so the
  // result appears with the ordinary latency.
  logic a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_nan    = (e  == EXP_MAX) && (m  != '0);
    b_nan    = (e0 == EXP_MAX) && (m0 != '0);
    a_inf    = (e  == EXP_MAX) && (m  == '0);
    b_inf    = (e0 == EXP_MAX) && (m0 == '0);
    sp_hit_d = 1'b0;
    sp_res_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (s != s0))) begin
      sp_hit_d = 1'b1;
      sp_res_d = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (a_inf) begin
      sp_hit_d = 1'b1;
      sp_res_d = {s, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      sp_hit_d = 1'b1;
      sp_res_d = {s0, EXP_MAX, {MAN_W{1'b0}}};
    end
  end
`endif

  // ---------------------------------------------------------------- align
  logic             a_ge_b, l_s;
  logic [EXP_W-1:0] l_e, r_e, diff, sh;
  logic [SIG_W-1:0] l_sig, r_sig;
  logic [EXT_W-1:0] r_ext, al_small;
  logic             al_sticky;

  always_comb begin
    a_ge_b    = (a_e > b_e) || ((a_e == b_e) && (a_sig >= b_sig));
    l_s       = a_ge_b ? a_s   : b_s;
    l_e       = a_ge_b ? a_e   : b_e;
    l_sig     = a_ge_b ? a_sig : b_sig;
    r_e       = a_ge_b ? b_e   : a_e;
    r_sig     = a_ge_b ? b_sig : a_sig;
    diff      = l_e - r_e;
    sh        = (diff > SHIFT_CAP) ? SHIFT_CAP : diff;
    r_ext     = {r_sig, 3'b000};
    // Everything shifted past the S position collapses into sticky.
    al_sticky = |(r_ext & ~({EXT_W{1'b1}} << sh));
    al_small  = r_ext >> sh;
    al_small[0] = al_small[0] | al_sticky;
  end

  // ---------------------------------------------------------------- add
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    if (eff_sub) sum_d = {1'b0, big_x} - {1'b0, small_x};
    else         sum_d = {1'b0, big_x} + {1'b0, small_x};
  end

  // ---------------------------------------------------------------- normalise
  logic [LZ_W-1:0]  lz;
  logic [XE_W-1:0]  exp_x, nexp_d;
  logic [EXT_W-1:0] nsig_d;
  logic             nzero_d, ns_d;

  always_comb begin
    lz = '0;
    // Highest set bit wins because it is visited last.
    for (int i = 0; i < EXT_W; i++) begin
      if (sum_q[i]) lz = LZ_W'(EXT_W - 1 - i);
    end
    exp_x   = {2'b00, big_e};
    nzero_d = 1'b0;
    ns_d    = big_s;
    if (sum_q[SUM_W-1]) begin
      nsig_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      nexp_d = exp_x + XE_W'(1);
    end else begin
      nsig_d = sum_q[EXT_W-1:0] << lz;
      nexp_d = exp_x - {{(XE_W-LZ_W){1'b0}}, lz};
    end
    if (sum_q == '0) begin
      nzero_d = 1'b1;
      ns_d    = neg_zero;
    end else if (nexp_d[XE_W-1] || (nexp_d == '0)) begin
      nzero_d = 1'b1;
      ns_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------- round
  logic                 rnd_up, rnd_norm;
  logic [SIG_W:0]       rnd;
  logic [XE_W-1:0]      exp_f;
  logic [EXP_W+MAN_W:0] res;

  always_comb begin
    // Round to nearest, ties to even: LSB, G, R, S are n_sig[3:0].
    rnd_up   = n_sig[2] & (n_sig[1] | n_sig[0] | n_sig[3]);
    rnd      = {1'b0, n_sig[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd_up};
    rnd_norm = rnd[SIG_W] | rnd[MAN_W];
    exp_f    = n_exp + {{(XE_W-1){1'b0}}, rnd[SIG_W]};
    if (n_zero || !rnd_norm) begin
      res = {n_s, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_f >= EXP_INF) begin
      res = {n_s, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      res = {n_s, exp_f[EXP_W-1:0], rnd[SIG_W] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
    end
`ifdef FP_ADD_SPECIAL_EN
    if (sp_hit_q) res = sp_res_q;
`endif
  end

  // ---------------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is plain flops, not a memory, so it takes the async
    // reset too; an aborted operation leaves nothing behind.
    if (!rst_n) begin
      a_s      <= 1'b0;
      b_s      <= 1'b0;
      a_e      <= '0;
      b_e      <= '0;
      a_sig    <= '0;
      b_sig    <= '0;
      big_s    <= 1'b0;
      eff_sub  <= 1'b0;
      neg_zero <= 1'b0;
      big_e    <= '0;
      big_x    <= '0;
      small_x  <= '0;
      sum_q    <= '0;
      n_zero   <= 1'b0;
      n_s      <= 1'b0;
      n_exp    <= '0;
      n_sig    <= '0;
      add      <= '0;
`ifdef FP_ADD_SPECIAL_EN
      sp_hit_q <= 1'b0;
      sp_res_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_s   <= s;
            b_s   <= s0;
            a_e   <= e;
            b_e   <= e0;
            a_sig <= in_sig_a;
            b_sig <= in_sig_b;
`ifdef FP_ADD_SPECIAL_EN
            sp_hit_q <= sp_hit_d;
            sp_res_q <= sp_res_d;
`endif
          end
        end
        ALIGN: begin
          big_s    <= l_s;
          big_e    <= l_e;
          big_x    <= {l_sig, 3'b000};
          small_x  <= al_small;
          eff_sub  <= a_s ^ b_s;
          neg_zero <= a_s & b_s;
        end
        ADD: sum_q <= sum_d;
        NORM: begin
          n_zero <= nzero_d;
          n_s    <= ns_d;
          n_exp  <= nexp_d;
          n_sig  <= nsig_d;
        end
        ROUND: add <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: randomized and directed checks of fp_add_seq against an exact
// wide-integer reference adder; honours FP_ADD_SPECIAL_EN like the design.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        s = 1'b0, s0 = 1'b0;
  logic [7:0]  e = '0, e0 = '0;
  logic [22:0] m = '0, m0 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] add;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .e         (e),
    .m         (m),
    .s0        (s0),
    .e0        (e0),
    .m0        (m0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add       (add),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // Exact value of a flushed operand in units of 2^-149.
  function automatic logic [319:0] mag_of(input logic [31:0] x);
    logic [319:0] v;
    if (x[30:23] == 8'h00) return '0;
    v = 320'({1'b1, x[22:0]});
    return v << (int'(x[30:23]) - 1);
  endfunction

  // Reference: exact signed sum, flush if below the normal range, RNE to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [319:0] va, vb, mag, kept, rem, half;
    logic         sr;
    int           p, k, ex;
`ifdef FP_ADD_SPECIAL_EN
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
        (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31]))
      return 32'h7FC00000;
    if (a[30:0] == 31'h7F800000) return a;
    if (b[30:0] == 31'h7F800000) return b;
`endif
    va = mag_of(a);
    vb = mag_of(b);
    if (a[31] == b[31])  begin mag = va + vb; sr = a[31]; end
    else if (va >= vb)   begin mag = va - vb; sr = a[31]; end
    else                 begin mag = vb - va; sr = b[31]; end
    if (mag == '0) return {a[31] & b[31], 31'h0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    ex = p - 22;
    if (ex <= 0) return 32'h0;
    k    = p - 23;
    kept = mag >> k;
    if (k > 0) begin
      rem  = mag - (kept << k);
      half = 320'(1) << (k - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 320'(1);
      if (kept[24]) begin
        kept = kept >> 1;
        ex++;
      end
    end
    if (ex >= 255) return {sr, 8'hFF, 23'h0};
    return {sr, 8'(ex), kept[22:0]};
  endfunction

  // One operation: drive at a negedge, measure latency, check result, hold OUT
  // for `hold` cycles with ignored in_valid pulses, then release.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int hold);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    {s, e, m}    = a;
    {s0, e0, m0} = b;
    in_valid     = 1'b1;
    out_ready    = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy"}, 32'({busy, in_ready, out_valid}), 32'b100);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " result"}, add, want);
    for (int i = 0; i < hold; i++) begin
      in_valid     = i[0];
      {s, e, m}    = $urandom;
      {s0, e0, m0} = $urandom;
      @(negedge clk);
      check({tag, " hold flags"}, 32'({out_valid, in_ready, busy}), 32'b101);
      check({tag, " hold add"}, add, want);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " idle"}, 32'({busy, out_valid, in_ready}), 32'b001);
  endtask

  logic [31:0] da [0:9] = '{32'h3F800000, 32'h3FC00000, 32'h80000000, 32'h3F800000,
                            32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h00400000,
                            32'h80400000, 32'h00800001};
  logic [31:0] db [0:9] = '{32'h3F800000, 32'hBFC00000, 32'h80000000, 32'h33800000,
                            32'h34400000, 32'h7F7FFFFF, 32'hFF800000, 32'h80000000,
                            32'h80000000, 32'h80800000};
`ifdef FP_ADD_SPECIAL_EN
  localparam logic [31:0] INF_DIFF = 32'h7FC00000;
`else
  localparam logic [31:0] INF_DIFF = 32'h00000000;
`endif
  logic [31:0] dw [0:9] = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h3F800000,
                            32'h3F800002, 32'h7F800000, INF_DIFF,     32'h00000000,
                            32'h80000000, 32'h00000000};

  initial begin
    logic [31:0] a, b, last;
    int          lat, seen;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("reset flags", 32'({busy, out_valid, in_ready}), 32'b001);
    check("reset add", add, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op("directed", da[i], db[i], dw[i], 0);

    // Result held in IDLE.
    last = add;
    repeat (3) @(negedge clk);
    check("idle hold add", add, dw[9]);

    // Backpressure: ten cycles of out_ready=0 in OUT.
    run_op("backpressure", 32'h3FC00000, 32'h3FA00000, ref_add(32'h3FC00000, 32'h3FA00000), 10);
    repeat (2) @(negedge clk);
    check("no queued op", 32'({busy, out_valid}), 32'b00);

    // in_valid held through the whole op, then coincident with out_ready in OUT.
    @(negedge clk);
    {s, e, m} = 32'h40490FDB; {s0, e0, m0} = 32'hC02DF854;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    {s, e, m} = 32'h3DCCCCCD; {s0, e0, m0} = 32'h3E4CCCCD;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("overlap latency", 32'(lat), 32'd5);
    check("overlap result", add, ref_add(32'h40490FDB, 32'hC02DF854));
    out_ready = 1'b1;
    @(negedge clk);
    check("overlap not taken", 32'({busy, out_valid, in_ready}), 32'b001);
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap accepted", 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("second latency", 32'(lat), 32'd5);
    check("second result", add, ref_add(32'h3DCCCCCD, 32'h3E4CCCCD));
    @(negedge clk);

    // Reset asserted while in NORM.
    @(negedge clk);
    {s, e, m} = 32'h3F800000; {s0, e0, m0} = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort flags", 32'({busy, out_valid, in_ready}), 32'b001);
    check("abort add", add, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid) seen++; end
    check("abort no output", 32'(seen), 32'd0);

    // Randomized operands against the reference.
    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        1: begin
          b[30:23] = a[30:23] ^ 8'($urandom_range(0, 3));
          b[31]    = ~a[31];
          if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
        end
        2: b[30:23] = a[30:23] - 8'($urandom_range(20, 30));
        3: begin
          a[30:23] = 8'($urandom_range(0, 3));
          b[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(0, 3));
          if ($urandom_range(0, 4) == 0) b[30:23] = 8'hFF;
        end
        default: ;
      endcase
      run_op("random", a, b, ref_add(a, b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
